chunked_add_sub: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry through a registered carry flop between chunks, so wide adds meet timing with a narrow carry chain. It replaces fixed-width combinational ripple adders wherever a start/done handshake is acceptable: datapath accumulators, address generators and test harnesses in the arithmetic library.

---
 rtl/arith_pkg.sv | 15 +
 rtl/chunk_adder.sv | 30 +++
 rtl/chunked_add_sub.sv | 141 ++++++++++++++
 tb/tb_chunked_add_sub.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the chunked arithmetic blocks: the controller
// state encoding and the default operand/chunk widths.
package arith_pkg;

    // Controller states: IDLE accepts a request, RUN walks the chunks.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default operand width and bits processed per clock.
    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

endpackage : arith_pkg

// File: rtl/chunk_adder.sv
// Purely combinational CHUNK-bit ripple-carry full-adder slice.
// The multi-cycle adder reuses one of these every clock, so the carry
// chain seen by timing is only CHUNK bits long.
module chunk_adder
    import arith_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] carry;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
        end
        co = carry[CHUNK];
    end

endmodule : chunk_adder

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit operand pair CHUNK
// bits per clock through a single chunk_adder, carrying between chunks in
// a registered carry flop. Subtraction is done as A + ~B + 1 (the +1 comes
// from presetting the carry flop), so cout reads as "no borrow".
// Optional feature macro: ADDER_OVERFLOW_EN builds the signed-overflow
// flag; without it the overflow port is tied low.
module chunked_add_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t state;
    state_t next_state;

    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_sum;
    logic [WIDTH-1:0] next_work;
    logic             carry;

    logic [CHUNK-1:0] x_slice;
    logic [CHUNK-1:0] y_slice;
    logic [CHUNK-1:0] s_slice;
    logic             co_slice;

    logic accept;
    logic finish;

    assign accept = (state == IDLE) && start;
    assign finish = (state == RUN) && (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a start in RUN is simply ignored.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start)  next_state = RUN;
            RUN:  if (finish) next_state = IDLE;
            default:          next_state = IDLE;
        endcase
    end

    // Output logic: ready only while idle.
    always_comb begin
        ready = (state == IDLE);
    end

    // Select the current chunk of both operands and merge the adder result
    // into the working sum so completion can register the full word.
    always_comb begin
        x_slice   = a_reg[int'(idx)*CHUNK +: CHUNK];
        y_slice   = b_reg[int'(idx)*CHUNK +: CHUNK];
        next_work = work_sum;
        next_work[int'(idx)*CHUNK +: CHUNK] = s_slice;
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .x (x_slice),
        .y (y_slice),
        .ci(carry),
        .s (s_slice),
        .co(co_slice)
    );

    // Datapath: load operands on accept, step one chunk per RUN cycle,
    // and publish the result registers on the final chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            work_sum <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                a_reg    <= a;
                b_reg    <= sub ? ~b : b;
                carry    <= cin ^ sub;
                work_sum <= '0;
                idx      <= '0;
            end else if (state == RUN) begin
                work_sum <= next_work;
                carry    <= co_slice;
                idx      <= finish ? '0 : idx + 1'b1;
                if (finish) begin
                    sum  <= next_work;
                    cout <= co_slice;
                end
            end
        end
    end

`ifdef ADDER_OVERFLOW_EN
    // Signed overflow: operands agree in sign but the result does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (finish) begin
            overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (next_work[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule : chunked_add_sub

// File: tb/tb_chunked_add_sub.sv
// Directed self-checking bench for chunked_add_sub: a 16/4 instance for the
// main scenarios and an 8/8 instance for the single-chunk case.
module tb_chunked_add_sub;

`ifdef ADDER_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, sub, cin;
    logic [15:0] a, b;
    logic        ready, done, cout, overflow;
    logic [15:0] sum;

    logic        rst8, start8, sub8, cin8;
    logic [7:0]  a8, b8;
    logic        ready8, done8, cout8, overflow8;
    logic [7:0]  sum8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
        .ready(ready), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    chunked_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .sub(sub8), .cin(cin8),
        .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .overflow(overflow8)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and let the accept edge happen.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                            input logic sv, input logic cv);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count cycles after the accept edge until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_add_wrap();
        int cyc;
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL wrap_busy ready got=%b exp=0", ready); end
        wait_done(cyc);
        checks++; if (cyc != 4) begin errors++; $display("[TB] FAIL wrap_latency got=%0d exp=4", cyc); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready got=%b exp=1", ready); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL wrap_cout got=%b exp=1", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ovf got=%b exp=0", overflow); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL wrap_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_sub_borrow();
        int cyc;
        start_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        wait_done(cyc);
        checks++; if (cyc != 4) begin errors++; $display("[TB] FAIL sub_latency got=%0d exp=4", cyc); end
        checks++; if (sum !== 16'hFFFE) begin errors++; $display("[TB] FAIL sub_sum got=%h exp=fffe", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL sub_cout got=%b exp=0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sub_ovf got=%b exp=0", overflow); end
        tick();
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(cyc);
        checks++; if (sum !== 16'hFFFD) begin errors++; $display("[TB] FAIL subcin_sum got=%h exp=fffd", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL subcin_cout got=%b exp=0", cout); end
        tick();
    endtask

    task automatic test_overflow();
        int cyc;
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(cyc);
        checks++; if (sum !== 16'h8000) begin errors++; $display("[TB] FAIL ovf_sum got=%h exp=8000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cout got=%b exp=0", cout); end
        checks++; if (overflow !== OVF_EN) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=%b", overflow, OVF_EN); end
        tick();
    endtask

    task automatic test_ignore_start();
        int cyc;
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL ignore_latency got=%0d exp=2", cyc); end
        checks++; if (sum !== 16'h2345) begin errors++; $display("[TB] FAIL ignore_sum got=%h exp=2345", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL ignore_cout got=%b exp=0", cout); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ignore_requeue ready got=%b exp=1", ready); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit held;
        start_op(16'h0100, 16'h0023, 1'b0, 1'b0);
        wait_done(cyc);
        checks++; if (sum !== 16'h0123) begin errors++; $display("[TB] FAIL b2b_first_sum got=%h exp=0123", sum); end
        start_op(16'h1000, 16'h0001, 1'b1, 1'b0);
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept ready got=%b exp=0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_drop got=%b exp=0", done); end
        held = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (sum !== 16'h0123) held = 1'b0;
            tick();
            cyc++;
        end
        checks++; if (!held) begin errors++; $display("[TB] FAIL b2b_hold got=changed exp=0123 held"); end
        checks++; if (cyc != 4) begin errors++; $display("[TB] FAIL b2b_latency got=%0d exp=4", cyc); end
        checks++; if (sum !== 16'h0FFF) begin errors++; $display("[TB] FAIL b2b_sum got=%h exp=0fff", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL b2b_cout got=%b exp=1", cout); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready got=%b exp=1", ready); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_cout got=%b exp=0", cout); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL rstmid_no_done got=pulse exp=none"); end
    endtask

    task automatic test_degenerate();
        int cyc;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0;
        tick();
        rst8 = 1'b0;
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checks++; if (ready8 !== 1'b0) begin errors++; $display("[TB] FAIL deg_busy ready got=%b exp=0", ready8); end
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++; if (cyc != 1) begin errors++; $display("[TB] FAIL deg_latency got=%0d exp=1", cyc); end
        checks++; if (sum8 !== 8'h00) begin errors++; $display("[TB] FAIL deg_sum got=%h exp=00", sum8); end
        checks++; if (cout8 !== 1'b1) begin errors++; $display("[TB] FAIL deg_cout got=%b exp=1", cout8); end
        checks++; if (overflow8 !== 1'b0) begin errors++; $display("[TB] FAIL deg_ovf got=%b exp=0", overflow8); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0;
        test_reset();
        test_add_wrap();
        test_sub_borrow();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_chunked_add_sub
